// File: rtl/cpu_nic_if.sv
// Bus bundle between the NIC and its surroundings: processor data-memory port plus router local port.
// Data vectors use big-endian numbering, so index 0 is the MSB and carries the virtual-channel bit.
interface cpu_nic_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
);
    // Processor side
    logic [ADDR_WIDTH-1:0] addr;
    logic [0:DATA_WIDTH-1] d_in;
    logic [0:DATA_WIDTH-1] d_out;
    logic                  nic_en;
    logic                  nic_wr_en;

    // Router side
    logic                  net_si;
    logic                  net_ri;
    logic [0:DATA_WIDTH-1] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [0:DATA_WIDTH-1] net_do;
    logic                  net_polarity;

    modport master (
        output addr, d_in, nic_en, nic_wr_en,
        output net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nic_en, nic_wr_en,
        input  net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cpu_nic.sv
// Memory-mapped NIC with a one-entry receive buffer and a one-entry transmit buffer;
// transmit is released only when the packet's VC bit matches the router's current polarity.
module cpu_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    cpu_nic_if.slave   io_nic
);
    localparam logic [ADDR_WIDTH-1:0] A_IN_BUF     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_IN_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_OUT_BUF    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_OUT_STATUS = ADDR_WIDTH'(3);

    logic [0:DATA_WIDTH-1] r_in_buf;
    logic                  r_in_full;
    logic [0:DATA_WIDTH-1] r_out_buf;
    logic                  r_out_full;

    logic w_rd_en;
    logic w_wr_en;
    logic w_in_accept;
    logic w_in_clear;
    logic w_out_load;
    logic w_so;

    assign w_rd_en     = io_nic.nic_en & ~io_nic.nic_wr_en;
    assign w_wr_en     = io_nic.nic_en &  io_nic.nic_wr_en;
    assign w_in_accept = io_nic.net_si & ~r_in_full;
    assign w_in_clear  = w_rd_en & (io_nic.addr == A_IN_BUF);
    // A write that finds the buffer occupied is lost, even if the occupant leaves on this edge.
    assign w_out_load  = w_wr_en & (io_nic.addr == A_OUT_BUF) & ~r_out_full;
    assign w_so        = ~i_reset & r_out_full & io_nic.net_ro
                       & (r_out_buf[0] == io_nic.net_polarity);

    // Receive buffer: capture from router when empty, release on processor read of in_buf.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_in_buf  <= '0;
            r_in_full <= 1'b0;
        end else begin
            if (w_in_accept) begin
                r_in_buf  <= io_nic.net_di;
                r_in_full <= 1'b1;
            end else if (w_in_clear) begin
                r_in_full <= 1'b0;
            end
        end
    end

    // Transmit buffer: load from processor when empty, release when the router takes it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_out_buf  <= io_nic.d_in;
                r_out_full <= 1'b1;
            end else if (w_so) begin
                r_out_full <= 1'b0;
            end
        end
    end

    // Processor read mux; status flags sit in the last (least significant) bit.
    always_comb begin
        io_nic.d_out = '0;
        if (w_rd_en) begin
            case (io_nic.addr)
                A_IN_BUF:     io_nic.d_out = r_in_buf;
                A_IN_STATUS:  io_nic.d_out = DATA_WIDTH'(r_in_full);
                A_OUT_STATUS: io_nic.d_out = DATA_WIDTH'(r_out_full);
                default:      io_nic.d_out = '0;
            endcase
        end else begin
            io_nic.d_out = '0;
        end
    end

    assign io_nic.net_ri = ~r_in_full;
    assign io_nic.net_so = w_so;
    assign io_nic.net_do = r_out_buf;
endmodule

// File: tb/tb_cpu_nic.sv
module tb_cpu_nic;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [63:0] q_in[$];
    logic [63:0] q_out[$];
    logic [63:0] exp_v;
    logic [63:0] got_v;

    cpu_nic_if bus();

    cpu_nic dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_nic  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.addr = 2'd0; bus.d_in = 64'd0; bus.nic_en = 1'b0; bus.nic_wr_en = 1'b0;
        bus.net_si = 1'b0; bus.net_di = 64'd0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [63:0] v);
        bus.addr = a; bus.nic_en = 1'b1; bus.nic_wr_en = 1'b0;
        @(negedge clk);
        v = bus.d_out;
        tick();
        bus.nic_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [63:0] v);
        bus.addr = a; bus.d_in = v; bus.nic_en = 1'b1; bus.nic_wr_en = 1'b1;
        tick();
        bus.nic_en = 1'b0; bus.nic_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        idle(); bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.net_ri !== 1'b1) begin failures++; $display("FAIL reset_ri got=%b exp=1", bus.net_ri); end
        checks++; if (bus.net_so !== 1'b0) begin failures++; $display("FAIL reset_so got=%b exp=0", bus.net_so); end
        checks++; if (bus.d_out !== 64'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.d_out); end
        checks++; if (bus.net_do !== 64'd0) begin failures++; $display("FAIL reset_do got=%h exp=0", bus.net_do); end
        cpu_read(2'd1, got_v);
        checks++; if (got_v !== 64'd0) begin failures++; $display("FAIL reset_in_status got=%h exp=0", got_v); end
        cpu_read(2'd3, got_v);
        checks++; if (got_v !== 64'd0) begin failures++; $display("FAIL reset_out_status got=%h exp=0", got_v); end
    endtask

    task automatic test_input();
        bus.net_si = 1'b1; bus.net_di = 64'h0123_4567_89AB_CDEF;
        q_in.push_back(64'h0123_4567_89AB_CDEF);
        tick();
        bus.net_si = 1'b0;
        @(negedge clk);
        checks++; if (bus.net_ri !== 1'b0) begin failures++; $display("FAIL in_ri_full got=%b exp=0", bus.net_ri); end
        cpu_read(2'd1, got_v);
        checks++; if (got_v !== 64'd1) begin failures++; $display("FAIL in_status got=%h exp=1", got_v); end
        cpu_read(2'd0, got_v);
        exp_v = q_in.pop_front();
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL in_data got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        checks++; if (bus.net_ri !== 1'b1) begin failures++; $display("FAIL in_ri_cleared got=%b exp=1", bus.net_ri); end
        cpu_read(2'd0, got_v);
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL in_stale got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_polarity();
        bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
        cpu_write(2'd2, 64'h8000_0000_0000_00AA);
        q_out.push_back(64'h8000_0000_0000_00AA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.net_so !== 1'b0) begin failures++; $display("FAIL pol_hold cyc=%0d got=%b exp=0", i, bus.net_so); end
            tick();
        end
        cpu_read(2'd3, got_v);
        checks++; if (got_v !== 64'd1) begin failures++; $display("FAIL pol_status_full got=%h exp=1", got_v); end
        bus.net_polarity = 1'b1;
        @(negedge clk);
        exp_v = q_out.pop_front();
        checks++; if (bus.net_so !== 1'b1) begin failures++; $display("FAIL pol_so got=%b exp=1", bus.net_so); end
        checks++; if (bus.net_do !== exp_v) begin failures++; $display("FAIL pol_do got=%h exp=%h", bus.net_do, exp_v); end
        tick();
        @(negedge clk);
        checks++; if (bus.net_so !== 1'b0) begin failures++; $display("FAIL pol_so_once got=%b exp=0", bus.net_so); end
        cpu_read(2'd3, got_v);
        checks++; if (got_v !== 64'd0) begin failures++; $display("FAIL pol_status_empty got=%h exp=0", got_v); end
        bus.net_polarity = 1'b0;
    endtask

    task automatic test_drop();
        bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
        cpu_write(2'd2, 64'h0000_0000_0000_5555);
        q_out.push_back(64'h0000_0000_0000_5555);
        cpu_write(2'd2, 64'h0000_0000_0000_1111);
        cpu_write(2'd0, 64'hFFFF_0000_0000_0001);
        cpu_write(2'd3, 64'hFFFF_0000_0000_0000);
        @(negedge clk);
        checks++; if (bus.net_so !== 1'b0) begin failures++; $display("FAIL drop_so_blocked got=%b exp=0", bus.net_so); end
        cpu_read(2'd1, got_v);
        checks++; if (got_v !== 64'd0) begin failures++; $display("FAIL drop_in_status got=%h exp=0", got_v); end
        // write collides with the departure edge and must still be dropped
        bus.net_ro = 1'b1;
        bus.addr = 2'd2; bus.d_in = 64'h0000_0000_0000_2222; bus.nic_en = 1'b1; bus.nic_wr_en = 1'b1;
        @(negedge clk);
        exp_v = q_out.pop_front();
        checks++; if (bus.net_so !== 1'b1) begin failures++; $display("FAIL drop_so got=%b exp=1", bus.net_so); end
        checks++; if (bus.net_do !== exp_v) begin failures++; $display("FAIL drop_do got=%h exp=%h", bus.net_do, exp_v); end
        tick();
        bus.nic_en = 1'b0; bus.nic_wr_en = 1'b0;
        @(negedge clk);
        checks++; if (bus.net_so !== 1'b0) begin failures++; $display("FAIL drop_after_so got=%b exp=0", bus.net_so); end
        checks++; if (bus.net_do !== exp_v) begin failures++; $display("FAIL drop_after_do got=%h exp=%h", bus.net_do, exp_v); end
        cpu_read(2'd3, got_v);
        checks++; if (got_v !== 64'd0) begin failures++; $display("FAIL drop_out_status got=%h exp=0", got_v); end
    endtask

    task automatic test_input_hold();
        bus.net_si = 1'b1; bus.net_di = 64'hAAAA_0000_0000_0001;
        q_in.push_back(64'hAAAA_0000_0000_0001);
        tick();
        bus.net_di = 64'hBBBB_0000_0000_0002;
        tick(); tick();
        cpu_read(2'd0, got_v);
        exp_v = q_in.pop_front();
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL hold_data got=%h exp=%h", got_v, exp_v); end
        @(negedge clk);
        checks++; if (bus.net_ri !== 1'b1) begin failures++; $display("FAIL hold_ri got=%b exp=1", bus.net_ri); end
        q_in.push_back(64'hBBBB_0000_0000_0002);
        tick();
        bus.net_si = 1'b0;
        cpu_read(2'd1, got_v);
        checks++; if (got_v !== 64'd1) begin failures++; $display("FAIL hold_status got=%h exp=1", got_v); end
        cpu_read(2'd0, got_v);
        exp_v = q_in.pop_front();
        checks++; if (got_v !== exp_v) begin failures++; $display("FAIL hold_next got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            bus.net_ro = 1'b1; bus.net_polarity = b[63];
            bus.net_si = 1'b1; bus.net_di = a;
            bus.addr = 2'd2; bus.d_in = b; bus.nic_en = 1'b1; bus.nic_wr_en = 1'b1;
            q_in.push_back(a); q_out.push_back(b);
            tick();
            idle();
            @(negedge clk);
            exp_v = q_out.pop_front();
            checks++; if (bus.net_so !== 1'b1) begin failures++; $display("FAIL b2b_so i=%0d got=%b exp=1", i, bus.net_so); end
            checks++; if (bus.net_do !== exp_v) begin failures++; $display("FAIL b2b_do i=%0d got=%h exp=%h", i, bus.net_do, exp_v); end
            cpu_read(2'd0, got_v);
            exp_v = q_in.pop_front();
            checks++; if (got_v !== exp_v) begin failures++; $display("FAIL b2b_in i=%0d got=%h exp=%h", i, got_v, exp_v); end
        end
    endtask

    task automatic test_reset_midflight();
        bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
        bus.net_si = 1'b1; bus.net_di = 64'hC0C0_0000_0000_0003;
        bus.addr = 2'd2; bus.d_in = 64'hD000_0000_0000_0004; bus.nic_en = 1'b1; bus.nic_wr_en = 1'b1;
        tick();
        idle();
        reset = 1'b1; bus.net_polarity = 1'b1;
        @(negedge clk);
        checks++; if (bus.net_so !== 1'b0) begin failures++; $display("FAIL rst_cycle_so got=%b exp=0", bus.net_so); end
        tick();
        reset = 1'b0; bus.net_polarity = 1'b0;
        q_in.delete(); q_out.delete();
        @(negedge clk);
        checks++; if (bus.net_ri !== 1'b1) begin failures++; $display("FAIL rst_mid_ri got=%b exp=1", bus.net_ri); end
        checks++; if (bus.net_so !== 1'b0) begin failures++; $display("FAIL rst_mid_so got=%b exp=0", bus.net_so); end
        checks++; if (bus.net_do !== 64'd0) begin failures++; $display("FAIL rst_mid_do got=%h exp=0", bus.net_do); end
        cpu_read(2'd1, got_v);
        checks++; if (got_v !== 64'd0) begin failures++; $display("FAIL rst_mid_in_status got=%h exp=0", got_v); end
        cpu_read(2'd3, got_v);
        checks++; if (got_v !== 64'd0) begin failures++; $display("FAIL rst_mid_out_status got=%h exp=0", got_v); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        test_reset();
        test_input();
        test_polarity();
        test_drop();
        test_input_hold();
        test_back_to_back();
        test_reset_midflight();
        checks++; if (q_in.size() + q_out.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", q_in.size() + q_out.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
